// File: rtl/ram_io_bus.sv
// Byte-wide memory responder for the CPU external bus: RAM, TX/RX byte FIFOs,
// status byte, halt flag and a snapshot-latched cycle counter at 0x30000.
module ram_io_bus #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt
);

  localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
  localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
  localparam logic [TxPtrW:0] TxDepthC  = (TxPtrW + 1)'(TX_DEPTH);
  localparam logic [TxPtrW:0] TxThreshC = (TxPtrW + 1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RxPtrW:0] RxDepthC  = (RxPtrW + 1)'(RX_DEPTH);

  logic [7:0] ram [2**ADDR_WIDTH];

  logic        is_io, is_ram, bus_go, is_load, is_store;
  logic [15:0] io_off;
  logic        unused_bits;

  assign is_io    = mem_a[17] & mem_a[16];
  assign is_ram   = ~mem_a[17];
  assign io_off   = mem_a[15:0];
  assign bus_go   = en & ~rst;
  assign is_load  = bus_go & ~mem_wr;
  assign is_store = bus_go & mem_wr;
  assign unused_bits = ^mem_a[31:18];

  logic ram_we, tx_push_req, halt_set, snap_latch;
  assign ram_we      = is_store & is_ram;
  assign tx_push_req = is_store & is_io & (io_off == 16'h0000);
  assign halt_set    = is_store & is_io & (io_off == 16'h0004);
  assign snap_latch  = is_load & is_io & (io_off == 16'h0008);

  // TX FIFO
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxPtrW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TxPtrW:0] tx_count_q, tx_count_d;
  logic            tx_full, tx_pop, tx_push_ok, tx_overflow_q;

  assign tx_valid   = (tx_count_q != '0);
  assign tx_full    = (tx_count_q == TxDepthC);
  assign tx_pop     = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign tx_push_ok = tx_push_req & (~tx_full | tx_pop);
  assign tx_data    = tx_valid ? tx_mem[tx_rd_ptr_q] : 8'h00;

  always_comb begin
    tx_count_d = tx_count_q;
    if (tx_push_ok && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
    else if (tx_pop && !tx_push_ok) tx_count_d = tx_count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      tx_count_q     <= '0;
      tx_overflow_q  <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push_ok) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)     tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      tx_count_q     <= tx_count_d;
      io_buffer_full <= (tx_count_d >= TxThreshC);
      if (tx_push_req && !tx_push_ok) tx_overflow_q <= 1'b1;
    end
  end

  // RX FIFO
  logic [7:0]        rx_mem [RX_DEPTH];
  logic [RxPtrW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RxPtrW:0]   rx_count_q;
  logic              rx_nonempty, rx_push, rx_pop;

  assign rx_nonempty = (rx_count_q != '0);
  assign rx_ready    = (rx_count_q != RxDepthC);
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = is_load & is_io & (io_off == 16'h0000) & rx_nonempty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (rx_pop && !rx_push) rx_count_q <= rx_count_q - 1'b1;
    end
  end

  // Counter, snapshot and halt
  logic [31:0] cycle_cnt_q, snapshot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      snapshot_q  <= '0;
      halt        <= 1'b0;
    end else begin
      if (en)         cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (snap_latch) snapshot_q  <= cycle_cnt_q;
      if (halt_set)   halt        <= 1'b1;
    end
  end

  // Read path
  logic [7:0] io_rdata, rd_data_d;

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      16'h0000: io_rdata = rx_nonempty ? rx_mem[rx_rd_ptr_q] : 8'h00;
      16'h0004: io_rdata = {5'b0, tx_overflow_q, tx_full, rx_nonempty};
      // Byte 0 returns the live count so all four bytes come from one instant.
      16'h0008: io_rdata = cycle_cnt_q[7:0];
      16'h0009: io_rdata = snapshot_q[15:8];
      16'h000A: io_rdata = snapshot_q[23:16];
      16'h000B: io_rdata = snapshot_q[31:24];
      default:  io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    rd_data_d = rd_data;
    if (is_load) begin
      if (is_ram)     rd_data_d = ram[mem_a[ADDR_WIDTH-1:0]];
      else if (is_io) rd_data_d = io_rdata;
      else            rd_data_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_a[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= rd_data_d;
  end

endmodule
